// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus.
// Accepts at most one unit per cycle and registers its tag and result as a one-cycle broadcast.
module cdb_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [N_REQ-1:0]           require,
  input  logic [N_REQ*DATA_W-1:0]    dataIn,
  input  logic [N_REQ*LABEL_W-1:0]   labelIn,
  output logic [N_REQ-1:0]           requireAC,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic [1:0]                 grantId,
  output logic                       errZeroLabel,
  output logic [15:0]                bcCount
);

  logic [1:0]         r_ptr;
  logic               r_bcen;
  logic [LABEL_W-1:0] r_label;
  logic [DATA_W-1:0]  r_data;
  logic [1:0]         r_gid;
  logic               r_err;
  logic [15:0]        r_cnt;

  logic               w_found;
  logic [1:0]         w_win;
  logic [1:0]         w_ptr_next;
  int unsigned        w_idx;
  logic [LABEL_W-1:0] w_label;
  logic [DATA_W-1:0]  w_data;
  logic [N_REQ-1:0]   w_ac;

  // Scan from the pointer upward with wrap; first asserted request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % N_REQ;
      if (!w_found && require[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx[1:0];
      end
    end
  end

  always_comb begin
    w_ac = '0;
    if (w_found && !nRST) begin
      w_ac[w_win] = 1'b1;
    end
  end

  assign w_label    = labelIn[w_win*LABEL_W +: LABEL_W];
  assign w_data     = dataIn[w_win*DATA_W +: DATA_W];
  assign w_ptr_next = (32'(w_win) == N_REQ - 1) ? 2'd0 : w_win + 2'd1;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      r_ptr   <= '0;
      r_bcen  <= 1'b0;
      r_label <= '0;
      r_data  <= '0;
      r_gid   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_next;
      if (w_label != '0) begin
        r_bcen  <= 1'b1;
        r_label <= w_label;
        r_data  <= w_data;
        r_gid   <= w_win;
        r_cnt   <= r_cnt + 16'd1;
      end else begin
        // A zero tag is still accepted so the unit is freed, but nothing is broadcast.
        r_bcen <= 1'b0;
        r_err  <= 1'b1;
      end
    end else begin
      r_bcen <= 1'b0;
    end
  end

  assign requireAC    = w_ac;
  assign BCEN         = r_bcen;
  assign BClabel      = r_label;
  assign BCdata       = r_data;
  assign grantId      = r_gid;
  assign errZeroLabel = r_err;
  assign bcCount      = r_cnt;

endmodule
